pipe_hazard_unit: RTL and testbench

//  Consumes the per-instruction control word from the ID-stage decoder (ReadRs/ReadRt/RegWrite/load/jump-branch)
//  and tracks it through private EX/MEM/WB shadow registers of the 5-stage MIPS pipeline.

---
 rtl/pipe_hazard_unit.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: load-use stall, redirect flush,
// EX operand forwarding selects and saturating stall/flush debug counters.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   hold            freeze shadow regs and counters
//   id_*            control word of the instruction now in ID
//   ex_redirect     taken branch/jump resolved in EX this cycle
//   stall, flush    pipeline control (combinational)
//   fwd_a, fwd_b    EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cnt       saturating count of advancing cycles with stall=1
//   flush_cnt       saturating count of advancing cycles with flush=1
module pipe_hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_read_rs,
  input  logic             id_read_rt,
  input  logic             id_reg_write,
  input  logic [4:0]       id_dst,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [4:0] dst;
    logic       ld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rrs;
    logic       rrt;
  } ex_ent_t;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [4:0] dst;
    logic       ld;
  } wb_ent_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_ent_t ex_q;
  ex_ent_t ex_nxt;
  wb_ent_t mem_q;
  wb_ent_t wb_q;

  function automatic logic writes(
    input logic       v,
    input logic       rw,
    input logic [4:0] dst,
    input logic [4:0] r
  );
    return v & rw & (dst == r) & (r != 5'd0);
  endfunction

  logic ex_hit;
  logic a_mem, a_wb;
  logic b_mem, b_wb;

  assign flush  = ex_redirect;
  assign ex_hit = (id_read_rs & writes(ex_q.v, ex_q.rw, ex_q.dst, id_rs))
                | (id_read_rt & writes(ex_q.v, ex_q.rw, ex_q.dst, id_rt));
  assign stall  = id_valid & ex_q.ld & ex_hit & ~flush;

  // A load in MEM has no data yet; the stall keeps its consumer one slot
  // further back, so such a match falls through to the WB check.
  assign a_mem = ex_q.rrs & ~mem_q.ld
               & writes(mem_q.v, mem_q.rw, mem_q.dst, ex_q.rs);
  assign a_wb  = ex_q.rrs & writes(wb_q.v, wb_q.rw, wb_q.dst, ex_q.rs);
  assign b_mem = ex_q.rrt & ~mem_q.ld
               & writes(mem_q.v, mem_q.rw, mem_q.dst, ex_q.rt);
  assign b_wb  = ex_q.rrt & writes(wb_q.v, wb_q.rw, wb_q.dst, ex_q.rt);

  always_comb begin
    fwd_a = 2'b00;
    unique case (1'b1)
      a_mem:          fwd_a = 2'b01;
      a_wb & ~a_mem:  fwd_a = 2'b10;
      default:        fwd_a = 2'b00;
    endcase
  end

  always_comb begin
    fwd_b = 2'b00;
    unique case (1'b1)
      b_mem:          fwd_b = 2'b01;
      b_wb & ~b_mem:  fwd_b = 2'b10;
      default:        fwd_b = 2'b00;
    endcase
  end

  always_comb begin
    ex_nxt = '0;
    if (id_valid & ~stall & ~flush) begin
      ex_nxt.v   = 1'b1;
      ex_nxt.rw  = id_reg_write;
      ex_nxt.dst = id_dst;
      ex_nxt.ld  = id_is_load;
      ex_nxt.rs  = id_rs;
      ex_nxt.rt  = id_rt;
      ex_nxt.rrs = id_read_rs;
      ex_nxt.rrt = id_read_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      wb_q      <= mem_q;
      mem_q.v   <= ex_q.v;
      mem_q.rw  <= ex_q.rw;
      mem_q.dst <= ex_q.dst;
      mem_q.ld  <= ex_q.ld;
      ex_q      <= ex_nxt;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed hazard scenarios then random traffic,
// all checked against an instruction-history reference model.
module tb_pipe_hazard_unit;

  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, hold, id_valid;
  logic [4:0]    id_rs, id_rt, id_dst;
  logic          id_read_rs, id_read_rt, id_reg_write, id_is_load;
  logic          ex_redirect;
  logic          stall, flush;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_read_rs(id_read_rs), .id_read_rt(id_read_rt),
    .id_reg_write(id_reg_write), .id_dst(id_dst),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    bit v; bit rw; bit ld; bit rrs; bit rrt;
    int rs; int rt; int dst;
  } ins_t;

  // hist[d] is the instruction issued d+1 cycles ago (EX, MEM, WB)
  ins_t hist[3];
  ins_t cur;
  ins_t bub;
  bit   m_redir, m_hold, m_rst;
  int   m_scnt, m_fcnt;
  int   passed = 0, failed = 0, total = 0;

  function automatic ins_t mk(bit v, int rs, int rt, bit rrs, bit rrt,
                              bit rw, int dst, bit ld);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.rrs = rrs; i.rrt = rrt;
    i.rw = rw; i.dst = dst; i.ld = ld;
    return i;
  endfunction

  function automatic bit wr(ins_t p, int r);
    return p.v && p.rw && p.dst == r && r != 0;
  endfunction

  function automatic bit m_stall();
    bit uses;
    uses = (cur.rrs && wr(hist[0], cur.rs)) || (cur.rrt && wr(hist[0], cur.rt));
    return cur.v && hist[0].ld && uses && !m_redir;
  endfunction

  // Youngest older producer wins; a load one slot ahead has no data yet.
  function automatic int m_fwd(bit rd, int r);
    if (!(hist[0].v && rd)) return 0;
    for (int d = 1; d <= 2; d++)
      if (wr(hist[d], r) && !(d == 1 && hist[d].ld)) return d;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input ins_t i, input bit redir, input bit hld, input bit r);
    cur = i; m_redir = redir; m_hold = hld; m_rst = r;
    id_valid = i.v; id_rs = 5'(i.rs); id_rt = 5'(i.rt);
    id_read_rs = i.rrs; id_read_rt = i.rrt; id_reg_write = i.rw;
    id_dst = 5'(i.dst); id_is_load = i.ld;
    ex_redirect = redir; hold = hld; rst = r;
  endtask

  task automatic stepx(input ins_t i, input bit redir = 0,
                       input bit hld = 0, input bit r = 0);
    drive(i, redir, hld, r);
    #2;
    chk("stall", int'(stall), int'(m_stall()));
    chk("flush", int'(flush), int'(m_redir));
    chk("fwd_a", int'(fwd_a), m_fwd(hist[0].rrs, hist[0].rs));
    chk("fwd_b", int'(fwd_b), m_fwd(hist[0].rrt, hist[0].rt));
    chk("stall_cnt", int'(stall_cnt), m_scnt);
    chk("flush_cnt", int'(flush_cnt), m_fcnt);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = bub;
    m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic tick();
    bit s;
    s = m_stall();
    @(posedge clk);
    if (m_rst) model_reset();
    else if (!m_hold) begin
      if (s && m_scnt < CMAX) m_scnt++;
      if (m_redir && m_fcnt < CMAX) m_fcnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (s || m_redir || !cur.v) ? bub : cur;
    end
    #1;
  endtask

  initial begin
    ins_t nop, lw, add, a8, s8, c8, z, zrd, lz, rnd;
    int sc, fc;
    bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
    nop = bub;
    lw  = mk(1, 29, 8, 1, 0, 1, 8, 1);
    add = mk(1, 8, 10, 1, 1, 1, 9, 0);
    a8  = mk(1, 10, 11, 1, 1, 1, 8, 0);
    s8  = mk(1, 10, 8, 1, 1, 1, 11, 0);
    c8  = mk(1, 8, 0, 1, 0, 1, 9, 0);
    z   = mk(1, 8, 0, 1, 0, 1, 0, 0);
    zrd = mk(1, 0, 0, 1, 1, 1, 9, 0);
    lz  = mk(1, 29, 0, 1, 0, 1, 0, 1);
    model_reset();

    drive(nop, 0, 0, 1);
    tick();
    stepx(nop);
    chk("rst_stall", int'(stall), 0);
    chk("rst_fwd_a", int'(fwd_a), 0);
    chk("rst_scnt", int'(stall_cnt), 0);
    tick();

    // load-use: one stall cycle then WB forwarding
    stepx(lw); tick();
    stepx(add); chk("t1_stall", int'(stall), 1); tick();
    stepx(add); chk("t1_stall_once", int'(stall), 0); tick();
    stepx(nop); chk("t1_fwd_a_wb", int'(fwd_a), 2); tick();

    // ALU producer back-to-back and with one nop gap
    stepx(a8); tick();
    stepx(s8); chk("t2_no_stall", int'(stall), 0); tick();
    stepx(nop); chk("t2_fwd_b_mem", int'(fwd_b), 1); tick();
    stepx(a8); tick();
    stepx(nop); tick();
    stepx(s8); tick();
    stepx(nop); chk("t2_fwd_b_wb", int'(fwd_b), 2); tick();

    // MEM and WB both produce $t0
    stepx(a8); tick();
    stepx(a8); tick();
    stepx(c8); tick();
    stepx(nop); chk("t3_mem_wins", int'(fwd_a), 1); tick();

    // register $0 is never a hazard
    stepx(z); tick();
    stepx(zrd); chk("t4_stall", int'(stall), 0); tick();
    stepx(nop);
    chk("t4_fwd_a", int'(fwd_a), 0);
    chk("t4_fwd_b", int'(fwd_b), 0);
    tick();
    stepx(lz); tick();
    stepx(zrd); chk("t4_ld_zero", int'(stall), 0); tick();

    // redirect coincident with load-use
    stepx(lw); tick();
    fc = m_fcnt;
    stepx(add, 1);
    chk("t5_stall", int'(stall), 0);
    chk("t5_flush", int'(flush), 1);
    tick();
    stepx(nop); chk("t5_fcnt", int'(flush_cnt), fc + 1); tick();

    // hold during a stall, then reset mid-stream
    stepx(lw); tick();
    sc = m_scnt;
    for (int k = 0; k < 3; k++) begin
      stepx(add, 0, 1);
      chk("t6_hold_stall", int'(stall), 1);
      chk("t6_hold_scnt", int'(stall_cnt), sc);
      tick();
    end
    stepx(add); chk("t6_stall", int'(stall), 1); tick();
    stepx(add);
    chk("t6_release", int'(stall), 0);
    chk("t6_scnt", int'(stall_cnt), sc + 1);
    tick();
    stepx(lw); tick();
    stepx(add, 0, 0, 1); tick();
    stepx(add);
    chk("t6_rst_stall", int'(stall), 0);
    chk("t6_rst_fwd_a", int'(fwd_a), 0);
    chk("t6_rst_fwd_b", int'(fwd_b), 0);
    chk("t6_rst_scnt", int'(stall_cnt), 0);
    chk("t6_rst_fcnt", int'(flush_cnt), 0);
    tick();

    for (int n = 0; n < 400; n++) begin
      rnd = mk($urandom_range(0, 9) < 8, $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               1'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 9) < 3);
      stepx(rnd, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) == 0);
      tick();
    end

    // counter saturation
    for (int k = 0; k < 10; k++) begin
      stepx(nop, 1); tick();
    end
    stepx(nop); chk("fcnt_sat", int'(flush_cnt), CMAX); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
